// File: rtl/ot_sender.sv
// Sender side of the 1-out-of-2 oblivious-transfer byte protocol.
// Publishes N, e, x0, x1, collects the blinded v, then returns m0', m1' masked with k_i = (v - x_i)^d mod N.
module ot_sender #(
  parameter int EXP_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] key_n,
  input  logic [31:0] key_e,
  input  logic [31:0] key_d,
  input  logic [31:0] rand0,
  input  logic [31:0] rand1,
  input  logic [31:0] msg0,
  input  logic [31:0] msg1,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SEND1 = 4'd1;
  localparam logic [3:0] S_RECV  = 4'd2;
  localparam logic [3:0] S_PREP0 = 4'd3;
  localparam logic [3:0] S_EXP0  = 4'd4;
  localparam logic [3:0] S_PREP1 = 4'd5;
  localparam logic [3:0] S_EXP1  = 4'd6;
  localparam logic [3:0] S_SEND2 = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam int               CNT_W    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXP_BITS - 1);

  // Control state (reset)
  logic [3:0]       state_q, state_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic [4:0]       byte_cnt_q, byte_cnt_d;

  // Datapath state (no reset)
  logic [127:0]     payload_q, payload_d;
  logic [31:0]      n_q, n_d;
  logic [31:0]      d_q, d_d;
  logic [31:0]      x0_q, x0_d;
  logic [31:0]      x1_q, x1_d;
  logic [31:0]      m0_q, m0_d;
  logic [31:0]      m1_q, m1_d;
  logic [31:0]      v_q, v_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      d_sh_q, d_sh_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  function automatic logic [31:0] mul_mod(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] n);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    p = p % {32'd0, n};
    return p[31:0];
  endfunction

  // (v - x) mod N without going negative: both operands are reduced first, then N is added.
  function automatic logic [31:0] sub_mod(input logic [31:0] v, input logic [31:0] x,
                                          input logic [31:0] n);
    logic [32:0] s;
    s = {1'b0, v % n} + {1'b0, n} - {1'b0, x % n};
    s = s % {1'b0, n};
    return s[31:0];
  endfunction

  function automatic logic [31:0] add_mod(input logic [31:0] m, input logic [31:0] k,
                                          input logic [31:0] n);
    logic [32:0] s;
    s = {1'b0, m % n} + {1'b0, k};
    s = s % {1'b0, n};
    return s[31:0];
  endfunction

  logic        n_big;
  logic        hs_tx;
  logic        hs_rx;
  logic        send_last;
  logic [31:0] base_init;
  logic [31:0] result_step;
  logic [31:0] base_step;
  logic [31:0] k_cur;
  logic [31:0] m_cur;
  logic [31:0] m_out;

  // Shared arithmetic: one base initialiser, one multiply-step pair and one masking adder
  // serve both halves of the exchange.
  always_comb begin
    n_big       = (n_q > 32'd1);
    hs_tx       = tx_valid_q && tx_ready;
    hs_rx       = rx_ready_q && rx_valid;
    send_last   = (state_q == S_SEND1) ? (byte_cnt_q == 5'd15) : (byte_cnt_q == 5'd7);
    base_init   = 32'd0;
    result_step = 32'd0;
    base_step   = 32'd0;
    if (n_big) begin
      base_init   = sub_mod(v_q, (state_q == S_PREP0) ? x0_q : x1_q, n_q);
      result_step = d_sh_q[0] ? mul_mod(result_q, base_q, n_q) : result_q;
      base_step   = mul_mod(base_q, base_q, n_q);
    end
    k_cur = (state_q == S_PREP1) ? result_q : result_step;
    m_cur = (state_q == S_PREP1) ? m0_q : m1_q;
    m_out = n_big ? add_mod(m_cur, k_cur, n_q) : m_cur;
  end

  // NOTE: every *_d is given its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rx_ready_d = rx_ready_q;
    byte_cnt_d = byte_cnt_q;
    payload_d  = payload_q;
    n_d        = n_q;
    d_d        = d_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    m0_d       = m0_q;
    m1_d       = m1_q;
    v_d        = v_q;
    base_d     = base_q;
    result_d   = result_q;
    d_sh_d     = d_sh_q;
    bit_cnt_d  = bit_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = key_n;
          d_d        = key_d;
          x0_d       = rand0;
          x1_d       = rand1;
          m0_d       = msg0;
          m1_d       = msg1;
          payload_d  = {rand1, rand0, key_e, key_n};
          tx_data_d  = key_n[7:0];
          tx_valid_d = 1'b1;
          byte_cnt_d = 5'd0;
          state_d    = S_SEND1;
        end
      end

      // The payload shifts down one byte per handshake; the next byte is registered
      // so it appears the cycle after the transfer.
      S_SEND1, S_SEND2: begin
        if (hs_tx) begin
          if (send_last) begin
            tx_valid_d = 1'b0;
            byte_cnt_d = 5'd0;
            if (state_q == S_SEND1) begin
              rx_ready_d = 1'b1;
              state_d    = S_RECV;
            end else begin
              state_d    = S_DONE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
            payload_d  = payload_q >> 8;
            tx_data_d  = payload_q[15:8];
          end
        end
      end

      S_RECV: begin
        if (hs_rx) begin
          v_d = {rx_data, v_q[31:8]};
          if (byte_cnt_q == 5'd3) begin
            rx_ready_d = 1'b0;
            byte_cnt_d = 5'd0;
            state_d    = S_PREP0;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end

      S_PREP0, S_PREP1: begin
        base_d    = base_init;
        result_d  = n_big ? 32'd1 : 32'd0;
        d_sh_d    = d_q;
        bit_cnt_d = '0;
        if (state_q == S_PREP1) begin
          payload_d = {96'd0, m_out};
          state_d   = S_EXP1;
        end else begin
          state_d   = S_EXP0;
        end
      end

      S_EXP0, S_EXP1: begin
        result_d  = result_step;
        base_d    = base_step;
        d_sh_d    = d_sh_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          if (state_q == S_EXP0) begin
            state_d = S_PREP1;
          end else begin
            payload_d  = {64'd0, m_out, payload_q[31:0]};
            tx_data_d  = payload_q[7:0];
            tx_valid_d = 1'b1;
            byte_cnt_d = 5'd0;
            state_d    = S_SEND2;
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      rx_ready_q <= 1'b0;
      byte_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_ready_q <= rx_ready_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // NOTE: datapath registers are left unreset; each is written before the FSM reads it.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
    n_q       <= n_d;
    d_q       <= d_d;
    x0_q      <= x0_d;
    x1_q      <= x1_d;
    m0_q      <= m0_d;
    m1_q      <= m1_d;
    v_q       <= v_d;
    base_q    <= base_d;
    result_q  <= result_d;
    d_sh_q    <= d_sh_d;
    bit_cnt_q <= bit_cnt_d;
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign rx_ready = rx_ready_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ot_sender.sv
// Bench for ot_sender: acts as the receiver peer, scoreboards every transmitted byte
// against an arithmetic model of the OT exchange.
module tb_ot_sender;

  localparam int EXP_BITS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] key_n, key_e, key_d, rand0, rand1, msg0, msg1;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        busy;
  logic        done;

  ot_sender #(.EXP_BITS(EXP_BITS)) dut (
    .clk(clk), .reset(reset), .start(start),
    .key_n(key_n), .key_e(key_e), .key_d(key_d),
    .rand0(rand0), .rand1(rand1), .msg0(msg0), .msg1(msg1),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          tx_cnt = 0;
  int          rx_cnt = 0;
  int          hs4_edge = 0;
  bit          lat_armed = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          garbage = 1'b0;
  bit          rx_armed = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [31:0] v_word = 32'd0;
  logic [7:0]  exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic, left-to-right exponentiation.
  function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % {32'd0, n};
      if (e[i]) r = (r * {32'd0, b}) % {32'd0, n};
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_key(input logic [31:0] v, input logic [31:0] x,
                                          input logic [31:0] n, input logic [31:0] d);
    logic [63:0] b;
    if (n < 32'd2) return 32'd0;
    b = ({32'd0, v % n} + {32'd0, n} - {32'd0, x % n}) % {32'd0, n};
    return ref_pow(b[31:0], d, n);
  endfunction

  function automatic logic [31:0] ref_msg(input logic [31:0] m, input logic [31:0] k,
                                          input logic [31:0] n);
    logic [63:0] s;
    if (n < 32'd2) return m;
    s = ({32'd0, m % n} + {32'd0, k}) % {32'd0, n};
    return s[31:0];
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Peer driver: tx_ready pattern and the rx byte stream, updated just after each edge.
  initial begin
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (garbage) begin
        rx_valid = 1'b1;
        rx_data  = (rx_ready && rx_cnt < 4) ? v_word[8*rx_cnt +: 8] : 8'($urandom);
      end else if (rx_armed && rx_cnt < 4) begin
        rx_valid = 1'b1;
        rx_data  = v_word[8*rx_cnt +: 8];
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
  end

  // Monitor: sees the values the DUT will sample at the next rising edge.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", 64'(tx_valid), 64'd1);
        check("tx_hold_data", 64'(tx_data), 64'(prev_data));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_extra: got byte 0x%0h, expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("tx_byte%0d", tx_cnt), 64'(tx_data), 64'(e));
        end
      end
      if (lat_armed && tx_valid) begin
        check("latency", 64'(cyc - hs4_edge), 64'(2 * EXP_BITS + 2));
        lat_armed = 1'b0;
      end
      if (rx_valid && rx_ready) begin
        rx_cnt++;
        if (rx_cnt == 4) begin
          hs4_edge  = cyc + 1;
          lat_armed = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic apply_keys(input logic [31:0] n, input logic [31:0] e, input logic [31:0] d,
                            input logic [31:0] x0, input logic [31:0] x1,
                            input logic [31:0] m0, input logic [31:0] m1);
    key_n = n; key_e = e; key_d = d; rand0 = x0; rand1 = x1; msg0 = m0; msg1 = m1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the inputs: the DUT must work from its latched copies.
    key_n = $urandom; key_e = $urandom; key_d = $urandom;
    rand0 = $urandom; rand1 = $urandom; msg0 = $urandom; msg1 = $urandom;
  endtask

  task automatic run_ot(input logic [31:0] n, input logic [31:0] e, input logic [31:0] d,
                        input logic [31:0] x0, input logic [31:0] x1,
                        input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] v,
                        input bit rr, input bit gb, input bit use_fixed,
                        input logic [31:0] m0_fixed);
    logic [31:0] k0, k1;
    int t;
    do_reset();
    exp_q.delete();
    tx_cnt    = 0;
    rx_cnt    = 0;
    lat_armed = 1'b0;
    v_word    = v;
    rdy_rand  = rr;
    garbage   = gb;
    k0 = ref_key(v, x0, n, d);
    k1 = ref_key(v, x1, n, d);
    push_word(n);
    push_word(e);
    push_word(x0);
    push_word(x1);
    push_word(use_fixed ? m0_fixed : ref_msg(m0, k0, n));
    push_word(ref_msg(m1, k1, n));
    rx_armed = 1'b1;
    apply_keys(n, e, d, x0, x1, m0, m1);
    t = 0;
    while (tx_cnt < 24 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got %0d tx bytes, expected 24", tx_cnt);
    end
    @(negedge clk);
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_tx_valid", 64'(tx_valid), 64'd0);
    check("end_sb_left", 64'(exp_q.size()), 64'd0);
    check("end_rx_count", 64'(rx_cnt), 64'd4);
    check("end_lat_seen", 64'(lat_armed), 64'd0);
    rx_armed = 1'b0;
    garbage  = 1'b0;
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [31:0] rn;
    reset = 1'b1;
    start = 1'b0;
    key_n = 0; key_e = 0; key_d = 0; rand0 = 0; rand1 = 0; msg0 = 0; msg1 = 0;

    // Reset in the middle of SEND1, right after the fifth byte.
    do_reset();
    exp_q.delete();
    tx_cnt = 0;
    push_word(32'd3233);
    push_word(32'd17);
    push_word(32'd100);
    push_word(32'd200);
    apply_keys(32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd1000, 32'd2000);
    t = 0;
    while (tx_cnt < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("mid_tx_count", 64'(tx_cnt), 64'd5);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    exp_q.delete();

    // Known RSA key: v = 2657 unblinds to k0 = 42, so m0' = 1042.
    run_ot(32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd1000, 32'd2000, 32'd2657,
           1'b0, 1'b0, 1'b1, 32'd1042);
    run_ot(32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd1000, 32'd2000, 32'd2657,
           1'b1, 1'b0, 1'b1, 32'd1042);
    run_ot(32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd1000, 32'd2000, 32'd2657,
           1'b1, 1'b1, 1'b1, 32'd1042);

    for (int i = 0; i < 5; i++) begin
      rn = (i % 2 == 0) ? $urandom : 32'($urandom_range(2, 5000));
      run_ot(rn, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'd0);
    end

    // Degenerate moduli: keys collapse to 0 and messages go out raw.
    run_ot(32'd0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           1'b1, 1'b0, 1'b0, 32'd0);
    run_ot(32'd1, 32'd5, $urandom, $urandom, $urandom, 32'hDEAD_BEEF, 32'h1234_5678, $urandom,
           1'b1, 1'b1, 1'b0, 32'd0);

    // A start pulse in DONE must be ignored.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("done_start_tx_valid", 64'(tx_valid), 64'd0);
    check("done_start_done", 64'(done), 64'd1);
    check("done_start_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
